sha256_round_ctrl: RTL
======================

// Module: sha256_round_ctrl
// PURPOSE
// - Sequencer for the SHA-256 compression datapath: owns chaining state H0..H7, loads it into the compressor,
//   streams 16 message words and steps round index I 0..63 with K[I].
// - Folds the final working variables a..h back into H, and flags the digest after the last block of a message.
// - Sits between the message padder (word stream) and MOD_COMPRESSOR; one compressor instance, one block in flight.
// PARAMETERS
// - ROUNDS     64  rounds per block; 64 in product, reducible only for bench bring-up
// - MSG_WORDS  16  words taken from the input stream per block (rounds 0..MSG_WORDS-1)
// PORTS
// - CLK           in   1    single clock, all state on posedge
// - RESET         in   1    synchronous, active-high
// - START         in   1    begin a block; accepted only when BUSY=0
// - FIRST         in   1    sampled with START: 1 = first block of message (H <= IV)
// - LAST          in   1    sampled with START: 1 = last block of message (raise DIGEST_VALID after it)
// - BUSY          out  1    block in progress (state != IDLE)
// - W_DATA        in   32   message word, big-endian word order
// - W_VALID       in   1    W_DATA valid
// - W_READY       out  1    controller takes a word this cycle when W_VALID & W_READY
// - CMP_LOAD      out  1    one-cycle pulse: compressor loads a..h from CMP_H0..7
// - CMP_EN        out  1    compressor advances one round
// - CMP_I         out  6    round index
// - CMP_K         out  32   K[CMP_I]
// - CMP_W         out  32   W_DATA passthrough (combinational)
// - CMP_H0..CMP_H7 out 32 each   current chaining values H0..H7
// - CMP_A..CMP_H  in   32 each   compressor working variables a..h
// - DIGEST        out  256  {H0,...,H7}, H0 in bits 255:224
// - DIGEST_VALID  out  1    digest of completed message is on DIGEST
// BEHAVIOUR
// - RESET: state=IDLE, I=0, H0..H7=IV (6a09e667..5be0cd19), DIGEST_VALID=0, CMP_LOAD=CMP_EN=W_READY=0, BUSY=0.
// - States: IDLE -> LOAD -> ROUND -> FINAL -> IDLE.
// - IDLE: START=1 -> LOAD; if FIRST then H <= IV on the same edge; latch LAST; DIGEST_VALID <= 0.
//   START while BUSY=1 is ignored; no queueing.
// - LOAD (1 cycle): CMP_LOAD=1 and CMP_H* stable; I <= 0; -> ROUND.
// - ROUND:
//   - W_READY = (I < MSG_WORDS).
//   - CMP_EN = (I >= MSG_WORDS) | W_VALID. On each CMP_EN cycle, I <= I+1.
//   - I < MSG_WORDS with W_VALID=0: stall; CMP_EN=0 and I holds.
//   - Enabled cycle with I=ROUNDS-1 -> FINAL; I wraps to 0.
// - FINAL (1 cycle): Hn <= Hn + CMP_{A..H} mod 2^32 (32-bit adds, carry dropped); -> IDLE.
//   DIGEST_VALID <= latched LAST.
// - No-stall latency: START sampled at edge 0; LOAD in cycle 1; I=0..63 in cycles 2..65; FINAL in cycle 66.
//   BUSY=0 and DIGEST_VALID=1 in cycle 67. Each stalled cycle adds 1.
// - DIGEST_VALID holds until the next accepted START or RESET. DIGEST = live H; stable while IDLE.
// - START with FIRST=0 chains on current H, including after DIGEST_VALID.
// - RESET mid-block: block discarded, all state back to reset values. Partial H is never exposed.
// - CMP_K = K[I] and CMP_I = I in every state; they are don't-care to the compressor unless CMP_EN=1.
// STRUCTURE
// - Package sha256_pkg: K[0:63] table, IV[0:7], state enum (IDLE/LOAD/ROUND/FINAL), word width 32.
// - Sub-module sha256_k_rom: combinational 64x32 ROM, index -> K; reused by later unrolled variants.
// - Remainder (FSM, counter, H bank, 8 adders) stays in this module.
// TESTING
// - "abc" single block, FIRST=LAST=1, W_VALID always 1
//   -> DIGEST=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at cycle 67.
// - 448-bit "abcdbcde...nopq" as 2 blocks (FIRST/LAST on 1st/2nd)
//   -> DIGEST_VALID low after block 1; after block 2 DIGEST=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
// - "abc" with W_VALID=0 for 5 cycles at I=3 -> I holds at 3, CMP_EN=0; same digest at cycle 72.
// - START pulsed at I=20 of a running block -> ignored; digest and timing unchanged.
// - RESET asserted at I=30 -> next cycle IDLE, BUSY=0, DIGEST=IV concatenation, DIGEST_VALID=0;
//   a fresh "abc" run then gives the correct digest.
// - ROUNDS=4 build, compare H after FINAL against a reference model (bring-up only).

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types: round constants K, initial hash IV, controller state encoding.
// Pure declarations; no logic, no latency.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL
    } state_e;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational 64x32 round-constant ROM, index -> K[index].
// Zero latency, no flow control.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx_i,
    output logic [31:0] k_o
);

    assign k_o = K[idx_i];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: owns H0..H7, loads the compressor, streams 16 words, steps 64 rounds, folds a..h into H.
// Latency START -> idle with digest = ROUNDS+3 cycles; each cycle with W_VALID low while a word is wanted adds one.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS    = 64,
    parameter int MSG_WORDS = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic         busy_o,
    input  logic [31:0]  w_data_i,
    input  logic         w_valid_i,
    output logic         w_ready_o,
    output logic         cmp_load_o,
    output logic         cmp_en_o,
    output logic [5:0]   cmp_i_o,
    output logic [31:0]  cmp_k_o,
    output logic [31:0]  cmp_w_o,
    output logic [31:0]  cmp_h0_o,
    output logic [31:0]  cmp_h1_o,
    output logic [31:0]  cmp_h2_o,
    output logic [31:0]  cmp_h3_o,
    output logic [31:0]  cmp_h4_o,
    output logic [31:0]  cmp_h5_o,
    output logic [31:0]  cmp_h6_o,
    output logic [31:0]  cmp_h7_o,
    input  logic [31:0]  cmp_a_i,
    input  logic [31:0]  cmp_b_i,
    input  logic [31:0]  cmp_c_i,
    input  logic [31:0]  cmp_d_i,
    input  logic [31:0]  cmp_e_i,
    input  logic [31:0]  cmp_f_i,
    input  logic [31:0]  cmp_g_i,
    input  logic [31:0]  cmp_h_i,
    output logic [255:0] digest_o,
    output logic         digest_valid_o
);

    localparam logic [5:0] MSG_W    = 6'(MSG_WORDS);
    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    word_t       h_q [0:7];
    word_t       h_d [0:7];
    logic        last_q, last_d;
    logic        dvld_q, dvld_d;
    word_t       work [0:7];

    assign work = '{cmp_a_i, cmp_b_i, cmp_c_i, cmp_d_i, cmp_e_i, cmp_f_i, cmp_g_i, cmp_h_i};

    sha256_k_rom u_k_rom (
        .idx_i (idx_q),
        .k_o   (cmp_k_o)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        h_d        = h_q;
        last_d     = last_q;
        dvld_d     = dvld_q;
        cmp_load_o = 1'b0;
        cmp_en_o   = 1'b0;
        w_ready_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    last_d  = last_i;
                    dvld_d  = 1'b0;
                    if (first_i) begin
                        h_d = IV;
                    end
                end
            end
            ST_LOAD: begin
                cmp_load_o = 1'b1;
                idx_d      = '0;
                state_d    = ST_ROUND;
            end
            ST_ROUND: begin
                // Message words feed rounds below MSG_WORDS; later rounds run from the compressor's schedule.
                w_ready_o = (idx_q < MSG_W);
                cmp_en_o  = (idx_q >= MSG_W) || w_valid_i;
                if (cmp_en_o) begin
                    if (idx_q == LAST_RND) begin
                        idx_d   = '0;
                        state_d = ST_FINAL;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_FINAL: begin
                for (int n = 0; n < 8; n++) begin
                    h_d[n] = h_q[n] + work[n];
                end
                dvld_d  = last_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            h_q     <= IV;
            last_q  <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            h_q     <= h_d;
            last_q  <= last_d;
            dvld_q  <= dvld_d;
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign cmp_i_o        = idx_q;
    assign cmp_w_o        = w_data_i;
    assign cmp_h0_o       = h_q[0];
    assign cmp_h1_o       = h_q[1];
    assign cmp_h2_o       = h_q[2];
    assign cmp_h3_o       = h_q[3];
    assign cmp_h4_o       = h_q[4];
    assign cmp_h5_o       = h_q[5];
    assign cmp_h6_o       = h_q[6];
    assign cmp_h7_o       = h_q[7];
    assign digest_o       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
    assign digest_valid_o = dvld_q;

endmodule
